// File: rtl/la_cmd_sequencer.sv
// Command sequencer between the SoC logic-analyzer probes and the user-project result/status pins.
// Runs LOAD / COUNT_UP / COUNT_DOWN commands received over a 4-phase valid/ack handshake.
module la_cmd_sequencer #(
  parameter int DATA_W   = 16,
  parameter int TICK_DIV = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] la_data_in,
  input  logic [31:0] la_oenb,
  output logic [31:0] la_data_out,
  output logic [17:0] io_out,
  output logic [17:0] io_oeb
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_EXEC = 2'b10;
  localparam logic [1:0] S_DONE = 2'b01;
  localparam logic [1:0] S_ERR  = 2'b11;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  logic [19:0]       la_eff;
  logic [DATA_W-1:0] arg_eff;
  logic [1:0]        op_eff;
  logic              valid_eff;
  logic              abort_eff;
  logic              unused_hi;

  // A probe bit the SoC is not driving (oenb=1) reads as 0.
  assign la_eff    = la_data_in[19:0] & ~la_oenb[19:0];
  assign arg_eff   = la_eff[DATA_W-1:0];
  assign op_eff    = la_eff[17:16];
  assign valid_eff = la_eff[18];
  assign abort_eff = la_eff[19];
  assign unused_hi = ^{la_data_in[31:20], la_oenb[31:20]};

  logic [1:0]        state_p0;
  logic [DATA_W-1:0] result_p0;
  logic [PW-1:0]     presc_p0;
  logic              oeb_p0;
  logic [DATA_W-1:0] arg_p0;
  logic [1:0]        op_p0;
  logic              accept;
  logic              tick;
  logic              ack;

  assign accept = (state_p0 == S_IDLE) && valid_eff && !abort_eff && (op_eff != OP_RSVD);
  assign tick   = (presc_p0 == TICK_LAST);

  // Stage p0: latched command, held constant for the whole EXEC phase
  always_ff @(posedge wb_clk_i) begin
    if (accept) begin
      arg_p0 <= arg_eff;
      op_p0  <= op_eff;
    end
  end

  // Stage p0: sequencer state, shared result register and step prescaler
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_p0  <= S_IDLE;
      result_p0 <= '0;
      presc_p0  <= '0;
      oeb_p0    <= 1'b1;
    end else begin
      oeb_p0 <= 1'b0;
      if (abort_eff) begin
        state_p0 <= S_IDLE;
        presc_p0 <= '0;
      end else begin
        case (state_p0)
          S_IDLE: begin
            if (valid_eff) begin
              if (op_eff == OP_RSVD) begin
                state_p0 <= S_ERR;
              end else begin
                state_p0  <= S_EXEC;
                presc_p0  <= '0;
                result_p0 <= (op_eff == OP_UP) ? '0 : arg_eff;
              end
            end
          end
          S_EXEC: begin
            // Terminal checks come before any step, so the count never wraps.
            if ((op_p0 == OP_LOAD) ||
                ((op_p0 == OP_UP) && (result_p0 == arg_p0)) ||
                ((op_p0 == OP_DOWN) && (result_p0 <= DATA_W'(1)))) begin
              state_p0 <= S_DONE;
            end else if (tick) begin
              presc_p0  <= '0;
              result_p0 <= (op_p0 == OP_UP) ? result_p0 + 1'b1 : result_p0 - 1'b1;
            end else begin
              presc_p0 <= presc_p0 + 1'b1;
            end
          end
          S_DONE, S_ERR: begin
            if (!valid_eff) state_p0 <= S_IDLE;
          end
          default: state_p0 <= S_IDLE;
        endcase
      end
    end
  end

  assign ack         = (state_p0 == S_DONE) || (state_p0 == S_ERR);
  assign la_data_out = {13'd0, ack, state_p0, result_p0};
  assign io_out      = {state_p0, result_p0};
  assign io_oeb      = {18{oeb_p0}};

endmodule

// File: tb/tb_la_cmd_sequencer.sv
// Bench for la_cmd_sequencer: a vector table, directed command sequences, and randomized
// commands compared against a closed-form per-command trajectory model.
module tb_la_cmd_sequencer;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] la_in;
  logic [31:0] oenb;
  logic [31:0] la_out;
  logic [17:0] io_out;
  logic [17:0] io_oeb;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] model_res;

  always #5 clk = ~clk;

  la_cmd_sequencer #(.DATA_W(16), .TICK_DIV(TD)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .la_data_in (la_in),
    .la_oenb    (oenb),
    .la_data_out(la_out),
    .io_out     (io_out),
    .io_oeb     (io_oeb)
  );

  typedef struct {
    logic [31:0] la;
    logic [31:0] oe;
    logic [1:0]  st;
    logic [15:0] res;
  } vec_t;

  vec_t tbl[17];

  function automatic logic [31:0] mk(input logic abort, input logic valid,
                                     input logic [1:0] op, input logic [15:0] arg);
    return {12'd0, abort, valid, op, arg};
  endfunction

  // Number of cycles spent in EXEC for a command.
  function automatic int exec_len(input logic [1:0] op, input logic [15:0] arg);
    case (op)
      2'b00:   return 1;
      2'b01:   return int'(arg) * TD + 1;
      2'b10:   return (arg <= 16'd1) ? 1 : (int'(arg) - 1) * TD + 1;
      default: return 0;
    endcase
  endfunction

  // Result visible k cycles after the command was accepted (k=0 is the accept edge).
  function automatic logic [15:0] exp_res(input logic [1:0] op, input logic [15:0] arg, input int k);
    case (op)
      2'b01:   return 16'(k / TD);
      2'b10:   return (arg <= 16'd1) ? arg : arg - 16'(k / TD);
      default: return arg;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string name, input logic [1:0] st, input logic [15:0] res);
    logic ack;
    ack = (st == 2'b01) || (st == 2'b11);
    chk({name, "/la_data_out"}, la_out, {13'd0, ack, st, res});
    chk({name, "/io_out"}, {14'd0, io_out}, {14'd0, st, res});
    chk({name, "/io_oeb"}, {14'd0, io_oeb}, 32'd0);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "/la_data_out"}, la_out, 32'd0);
    chk({name, "/io_out"}, {14'd0, io_out}, 32'd0);
    chk({name, "/io_oeb"}, {14'd0, io_oeb}, 32'h3FFFF);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [15:0] arg, input int abort_k,
                         input int hold, input bit junk);
    int          len;
    logic [15:0] r;
    la_in = mk(1'b0, 1'b1, op, arg);
    if (junk) begin
      la_in[31:20] = 12'($urandom);
      oenb[31:20]  = 12'($urandom);
    end
    step();
    if (op == 2'b11) begin
      chk_state("err_enter", 2'b11, model_res);
      repeat (hold) begin
        step();
        chk_state("err_hold", 2'b11, model_res);
      end
      la_in = 32'd0;
      step();
      chk_state("err_exit", 2'b00, model_res);
      return;
    end
    len = exec_len(op, arg);
    for (int k = 0; k < len; k++) begin
      r = exp_res(op, arg, k);
      chk_state("exec", 2'b10, r);
      if (k == abort_k) begin
        la_in = mk(1'b1, 1'b1, op, arg);
        step();
        chk_state("abort", 2'b00, r);
        model_res = r;
        la_in = 32'd0;
        step();
        chk_state("post_abort", 2'b00, r);
        return;
      end
      if (junk) la_in = mk(1'b0, 1'b1, 2'($urandom), 16'($urandom)) | {12'($urandom), 20'd0};
      step();
    end
    r = exp_res(op, arg, len - 1);
    chk_state("done", 2'b01, r);
    repeat (hold) begin
      step();
      chk_state("done_hold", 2'b01, r);
    end
    la_in = 32'd0;
    step();
    chk_state("idle", 2'b00, r);
    model_res = r;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int          len;
    int          ak;
    logic [1:0]  op;
    logic [15:0] arg;

    tbl[0]  = '{mk(0, 1, 2'd0, 16'hA5A5), 32'd0,        2'b10, 16'hA5A5};
    tbl[1]  = '{mk(0, 1, 2'd0, 16'hA5A5), 32'd0,        2'b01, 16'hA5A5};
    tbl[2]  = '{mk(0, 1, 2'd0, 16'hA5A5), 32'd0,        2'b01, 16'hA5A5};
    tbl[3]  = '{32'd0,                    32'd0,        2'b00, 16'hA5A5};
    tbl[4]  = '{mk(0, 1, 2'd3, 16'h1234), 32'd0,        2'b11, 16'hA5A5};
    tbl[5]  = '{mk(0, 1, 2'd3, 16'h1234), 32'd0,        2'b11, 16'hA5A5};
    tbl[6]  = '{32'd0,                    32'd0,        2'b00, 16'hA5A5};
    tbl[7]  = '{mk(0, 1, 2'd0, 16'h1111), 32'h0004_0000, 2'b00, 16'hA5A5};
    tbl[8]  = '{mk(0, 1, 2'd3, 16'h0042), 32'h0003_0000, 2'b10, 16'h0042};
    tbl[9]  = '{mk(0, 1, 2'd0, 16'h0000), 32'd0,        2'b01, 16'h0042};
    tbl[10] = '{32'd0,                    32'd0,        2'b00, 16'h0042};
    tbl[11] = '{mk(0, 1, 2'd0, 16'hFFFF), 32'h0000_00FF, 2'b10, 16'hFF00};
    tbl[12] = '{mk(1, 1, 2'd0, 16'hFFFF), 32'd0,        2'b00, 16'hFF00};
    tbl[13] = '{mk(1, 1, 2'd0, 16'h1234), 32'd0,        2'b00, 16'hFF00};
    tbl[14] = '{mk(1, 1, 2'd0, 16'h1234), 32'h0008_0000, 2'b10, 16'h1234};
    tbl[15] = '{32'd0,                    32'd0,        2'b01, 16'h1234};
    tbl[16] = '{32'd0,                    32'd0,        2'b00, 16'h1234};

    rst   = 1'b1;
    la_in = 32'd0;
    oenb  = 32'd0;
    repeat (2) step();
    chk_reset("por");
    rst = 1'b0;
    #1;
    chk("por_release/io_oeb", {14'd0, io_oeb}, 32'h3FFFF);
    step();
    chk_state("por_first_edge", 2'b00, 16'h0000);

    for (int i = 0; i < 17; i++) begin
      la_in = tbl[i].la;
      oenb  = tbl[i].oe;
      step();
      chk_state($sformatf("vec%0d", i), tbl[i].st, tbl[i].res);
    end
    la_in     = 32'd0;
    oenb      = 32'd0;
    model_res = tbl[16].res;

    run_cmd(2'b00, 16'hA5A5, -1, 2, 1'b0);
    run_cmd(2'b10, 16'd5,    -1, 2, 1'b0);
    run_cmd(2'b01, 16'd0,    -1, 1, 1'b0);
    run_cmd(2'b01, 16'd3,    -1, 1, 1'b0);
    run_cmd(2'b11, 16'h0001, -1, 50, 1'b0);
    run_cmd(2'b01, 16'd100,  29, 0, 1'b0);
    run_cmd(2'b10, 16'd0,    -1, 0, 1'b0);
    run_cmd(2'b10, 16'd1,    -1, 0, 1'b0);
    run_cmd(2'b10, 16'd2,    -1, 0, 1'b1);
    run_cmd(2'b00, 16'h7777, 0,  0, 1'b0);

    // Asynchronous reset in the middle of a long count.
    la_in = mk(1'b0, 1'b1, 2'b01, 16'd100);
    repeat (21) step();
    chk_state("pre_reset", 2'b10, 16'd5);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("mid_exec_reset");
    la_in = 32'd0;
    step();
    chk_reset("reset_held");
    rst = 1'b0;
    #1;
    chk("reset_release/io_oeb", {14'd0, io_oeb}, 32'h3FFFF);
    step();
    chk_state("after_reset", 2'b00, 16'h0000);
    model_res = 16'h0000;

    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      arg = (op == 2'b00) ? 16'($urandom) : 16'($urandom_range(0, 20));
      len = exec_len(op, arg);
      ak  = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_cmd(op, arg, ak, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
